// File: rtl/lsu_pkg.sv
// ----------------------------------------------------------------------------
// lsu_pkg
// Shared definitions for the LSU store path: RISC-V store funct3 encodings,
// the byte-enable width and the layout of one buffered store entry.
//
// The entry's word-address field is sized from LSU_AW. LSU_AW is the default
// byte-address width of lsu_store_buffer, and the buffer's AW must not exceed it.
// ----------------------------------------------------------------------------
package lsu_pkg;

    localparam logic [2:0] F3_SB = 3'b000;
    localparam logic [2:0] F3_SH = 3'b001;
    localparam logic [2:0] F3_SW = 3'b010;

    localparam int BE_W   = 4;
    localparam int LSU_AW = 32;

    // One queued store: word address (byte address >> 2), lane-aligned data
    // and the byte enables that select which lanes are written.
    typedef struct packed {
        logic [LSU_AW-3:0] word_addr;
        logic [31:0]       wdata;
        logic [BE_W-1:0]   be;
    } store_entry_t;

endpackage

// File: rtl/store_lane_align.sv
// ----------------------------------------------------------------------------
// store_lane_align
// Combinational store formatter. It replicates the store data across the byte
// lanes, builds the byte-enable mask from the low address bits and flags
// misaligned or unsupported stores.
//
// Ports:
//   i_funct3   store width encoding (SB/SH/SW)
//   i_offset   byte offset inside the word (address bits [1:0])
//   i_data     rs2 value, right-justified
//   o_wdata    data replicated onto the byte lanes
//   o_be       byte enables; bit n enables lane n
//   o_illegal  store is misaligned or funct3 is not a store width
// ----------------------------------------------------------------------------
module store_lane_align
    import lsu_pkg::*;
(
    input  logic [2:0]      i_funct3,
    input  logic [1:0]      i_offset,
    input  logic [31:0]     i_data,
    output logic [31:0]     o_wdata,
    output logic [BE_W-1:0] o_be,
    output logic            o_illegal
);

    // Data is replicated so that whichever lane the enables select already
    // carries the right byte. Memory then needs no shifter of its own.
    always_comb begin
        o_wdata   = '0;
        o_be      = '0;
        o_illegal = 1'b0;
        case (i_funct3)
            F3_SB: begin
                o_wdata = {4{i_data[7:0]}};
                o_be    = 4'b0001 << i_offset;
            end
            F3_SH: begin
                o_wdata   = {2{i_data[15:0]}};
                o_be      = 4'b0011 << i_offset;
                o_illegal = i_offset[0];
            end
            F3_SW: begin
                o_wdata   = i_data;
                o_be      = 4'b1111;
                o_illegal = (i_offset != 2'b00);
            end
            default: begin
                o_illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/lsu_store_buffer.sv
// ----------------------------------------------------------------------------
// lsu_store_buffer
// Small in-order store FIFO between execute and the data-memory write port.
// Stores are lane-aligned on entry, drained head-first over a req/gnt
// handshake, and exposed to the load path as a word-granular hazard flag.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   st_valid/st_ready     store handshake from execute
//   st_addr/st_funct3     store byte address and width encoding
//   st_data               rs2 value, right-justified
//   st_err                one-cycle pulse after a rejected (illegal) store
//   mem_req/mem_gnt       write request to data memory / acceptance
//   mem_addr/wdata/be     head entry: word-aligned address, lane data, enables
//   ld_addr/ld_hit        load address in / buffered-store word match out
//   empty                 no buffered stores (registered)
// ----------------------------------------------------------------------------
module lsu_store_buffer
    import lsu_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = LSU_AW
)
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            st_valid,
    output logic            st_ready,
    input  logic [AW-1:0]   st_addr,
    input  logic [2:0]      st_funct3,
    input  logic [31:0]     st_data,
    output logic            st_err,
    output logic            mem_req,
    input  logic            mem_gnt,
    output logic [AW-1:0]   mem_addr,
    output logic [31:0]     mem_wdata,
    output logic [BE_W-1:0] mem_be,
    input  logic [AW-1:0]   ld_addr,
    output logic            ld_hit,
    output logic            empty
);

    localparam int         PW         = $clog2(DEPTH);
    localparam logic [PW:0] FULL_COUNT = (PW+1)'(DEPTH);

    logic [PW-1:0]  r_wrPtr;
    logic [PW-1:0]  r_rdPtr;
    logic [PW:0]    r_count;
    logic [DEPTH-1:0] r_valid;
    logic           r_empty;
    logic           r_stErr;
    store_entry_t   r_entries [DEPTH];

    logic [31:0]     w_alignData;
    logic [BE_W-1:0] w_alignBe;
    logic            w_illegal;
    logic            w_handshake;
    logic            w_push;
    logic            w_pop;
    logic [PW:0]     w_countNext;
    store_entry_t    w_pushEntry;
    store_entry_t    w_head;
    logic [LSU_AW-3:0] w_ldWord;
    logic            w_ldHit;
    logic            w_unusedLdLo;

    store_lane_align u_align (
        .i_funct3  (st_funct3),
        .i_offset  (st_addr[1:0]),
        .i_data    (st_data),
        .o_wdata   (w_alignData),
        .o_be      (w_alignBe),
        .o_illegal (w_illegal)
    );

    // Ready depends only on the registered count, so grant never reaches it
    // combinationally; a pop while full frees the slot one cycle later.
    assign st_ready    = (r_count != FULL_COUNT);
    assign w_handshake = st_valid && st_ready;
    assign w_push      = w_handshake && !w_illegal;
    assign mem_req     = (r_count != '0);
    assign w_pop       = mem_req && mem_gnt;

    assign w_pushEntry.word_addr = (LSU_AW-2)'(st_addr[AW-1:2]);
    assign w_pushEntry.wdata     = w_alignData;
    assign w_pushEntry.be        = w_alignBe;

    always_comb begin
        w_countNext = r_count;
        case ({w_push, w_pop})
            2'b10:   w_countNext = r_count + 1'b1;
            2'b01:   w_countNext = r_count - 1'b1;
            default: w_countNext = r_count;
        endcase
    end

    // Pointer, count and valid-bit state. A push and a pop never target the
    // same slot: a pop needs count > 0 and a push needs count < DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
            r_valid <= '0;
            r_empty <= 1'b1;
            r_stErr <= 1'b0;
        end else begin
            if (w_push) begin
                r_valid[r_wrPtr] <= 1'b1;
                r_wrPtr          <= r_wrPtr + 1'b1;
            end
            if (w_pop) begin
                r_valid[r_rdPtr] <= 1'b0;
                r_rdPtr          <= r_rdPtr + 1'b1;
            end
            r_count <= w_countNext;
            r_empty <= (w_countNext == '0);
            r_stErr <= w_handshake && w_illegal;
        end
    end

    // Entry payload needs no reset: valid bits and count gate every use of it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_entries[r_wrPtr] <= w_pushEntry;
        end
    end

    // Head fields are forced to zero when nothing is queued, which keeps the
    // port quiet out of reset. They are stable while a request waits for grant.
    assign w_head    = r_entries[r_rdPtr];
    assign mem_addr  = mem_req ? {(AW-2)'(w_head.word_addr), 2'b00} : '0;
    assign mem_wdata = mem_req ? w_head.wdata : '0;
    assign mem_be    = mem_req ? w_head.be    : '0;

    // Word-granular hazard check that ignores byte enables. An entry popped
    // this cycle is still valid here. A store being pushed is not yet valid.
    assign w_ldWord     = (LSU_AW-2)'(ld_addr[AW-1:2]);
    assign w_unusedLdLo = ^ld_addr[1:0];

    always_comb begin
        w_ldHit = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_valid[i] && (r_entries[i].word_addr == w_ldWord)) begin
                w_ldHit = 1'b1;
            end
        end
    end

    assign ld_hit = w_ldHit;
    assign empty  = r_empty;
    assign st_err = r_stErr;

endmodule

// File: tb/tb_lsu_store_buffer.sv
// ----------------------------------------------------------------------------
// tb_lsu_store_buffer
// Directed and randomized checks of lsu_store_buffer against a queue-based
// model of the store buffer's behaviour.
// ----------------------------------------------------------------------------
module tb_lsu_store_buffer;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        st_valid;
    logic        st_ready;
    logic [31:0] st_addr;
    logic [2:0]  st_funct3;
    logic [31:0] st_data;
    logic        st_err;
    logic        mem_req;
    logic        mem_gnt;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic [31:0] ld_addr;
    logic        ld_hit;
    logic        empty;

    lsu_store_buffer #(.DEPTH(DEPTH), .AW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .st_valid  (st_valid),
        .st_ready  (st_ready),
        .st_addr   (st_addr),
        .st_funct3 (st_funct3),
        .st_data   (st_data),
        .st_err    (st_err),
        .mem_req   (mem_req),
        .mem_gnt   (mem_gnt),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_be    (mem_be),
        .ld_addr   (ld_addr),
        .ld_hit    (ld_hit),
        .empty     (empty)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of pending writes, each kept as the
    // word-aligned byte address, the lane data and the byte enables.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } modelEntry_t;

    modelEntry_t modelQ[$];
    logic        modelErr;
    int          checks;
    int          failures;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic bit modelLegal(input logic [2:0] f3, input logic [31:0] a);
        case (f3)
            3'd0:    return 1'b1;
            3'd1:    return (a % 2) == 0;
            3'd2:    return (a % 4) == 0;
            default: return 1'b0;
        endcase
    endfunction

    function automatic modelEntry_t modelAlign(input logic [2:0] f3, input logic [31:0] a,
                                               input logic [31:0] d);
        modelEntry_t e;
        int off;
        off     = int'(a % 4);
        e.addr  = a - (a % 4);
        e.wdata = d;
        e.be    = 4'hF;
        if (f3 == 3'd0) begin
            e.wdata = d[7:0] * 32'h0101_0101;
            e.be    = 4'(1 << off);
        end else if (f3 == 3'd1) begin
            e.wdata = d[15:0] * 32'h0001_0001;
            e.be    = 4'(3 << off);
        end
        return e;
    endfunction

    task automatic applyStimulus(input logic v, input logic [2:0] f3, input logic [31:0] a,
                                 input logic [31:0] d, input logic gnt, input logic [31:0] ld);
        st_valid  = v;
        st_funct3 = f3;
        st_addr   = a;
        st_data   = d;
        mem_gnt   = gnt;
        ld_addr   = ld;
        #1;
    endtask

    task automatic checkOutput(input string tag);
        logic        expReq;
        logic        expHit;
        expReq = (modelQ.size() != 0);
        expHit = 1'b0;
        foreach (modelQ[i]) begin
            if (modelQ[i].addr[31:2] == ld_addr[31:2]) expHit = 1'b1;
        end
        chk($sformatf("%s.ready", tag), st_ready, (modelQ.size() < DEPTH));
        chk($sformatf("%s.empty", tag), empty, !expReq);
        chk($sformatf("%s.err", tag), st_err, modelErr);
        chk($sformatf("%s.req", tag), mem_req, expReq);
        chk($sformatf("%s.addr", tag), mem_addr, expReq ? modelQ[0].addr : 32'h0);
        chk($sformatf("%s.wdata", tag), mem_wdata, expReq ? modelQ[0].wdata : 32'h0);
        chk($sformatf("%s.be", tag), mem_be, expReq ? modelQ[0].be : 4'h0);
        chk($sformatf("%s.ldhit", tag), ld_hit, expHit);
    endtask

    // Advance one clock and update the model from the inputs that were
    // present before the edge.
    task automatic tick();
        bit          pop;
        bit          hs;
        bit          legal;
        modelEntry_t e;
        pop   = (modelQ.size() != 0) && mem_gnt;
        hs    = st_valid && (modelQ.size() < DEPTH);
        legal = modelLegal(st_funct3, st_addr);
        e     = modelAlign(st_funct3, st_addr, st_data);
        @(posedge clk);
        #1;
        if (!rst_n) begin
            modelQ.delete();
            modelErr = 1'b0;
        end else begin
            if (pop) void'(modelQ.pop_front());
            if (hs && legal) modelQ.push_back(e);
            modelErr = hs && !legal;
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        modelErr = 1'b0;
        rst_n    = 1'b0;
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
        @(posedge clk);
        #1;
        tick();
        checkOutput("reset");

        rst_n = 1'b1;

        // SB at 0x1003 with grant already high.
        applyStimulus(1'b1, 3'd0, 32'h1003, 32'h0000_00AB, 1'b1, 32'h0);
        checkOutput("sb.push");
        tick();
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h0);
        checkOutput("sb.drain");
        chk("sb.memAddr", mem_addr, 32'h1000);
        chk("sb.memBe", mem_be, 4'b1000);
        chk("sb.memWdata", mem_wdata, 32'hABAB_ABAB);
        tick();
        checkOutput("sb.done");
        chk("sb.empty", empty, 1'b1);

        // SH at 0x2002 held off by memory for three cycles.
        applyStimulus(1'b1, 3'd1, 32'h2002, 32'h0000_1234, 1'b0, 32'h0);
        tick();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
            checkOutput("sh.wait");
            chk("sh.memBe", mem_be, 4'b1100);
            chk("sh.memWdata", mem_wdata, 32'h1234_1234);
            tick();
        end
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h0);
        checkOutput("sh.grant");
        tick();
        checkOutput("sh.done");
        chk("sh.empty", empty, 1'b1);

        // Misaligned SW and SH are rejected with a single error pulse.
        for (int k = 0; k < 2; k++) begin
            applyStimulus(1'b1, (k == 0) ? 3'd2 : 3'd1, 32'h3001, 32'hDEAD_BEEF, 1'b0, 32'h0);
            checkOutput("bad.push");
            tick();
            applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h0);
            checkOutput("bad.err");
            chk("bad.errPulse", st_err, 1'b1);
            chk("bad.noReq", mem_req, 1'b0);
            tick();
            checkOutput("bad.after");
            chk("bad.errClear", st_err, 1'b0);
        end

        // Fill with four SWs, try a fifth, then drain in order.
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b1, 3'd2, 32'h10 + 32'(4 * i), 32'h100 + 32'(i), 1'b0, 32'h0);
            checkOutput("fill");
            tick();
        end
        applyStimulus(1'b1, 3'd2, 32'h20, 32'h5555_5555, 1'b0, 32'h0);
        checkOutput("full");
        chk("full.notReady", st_ready, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h0);
            checkOutput("drain");
            chk("drain.order", mem_addr, 32'h10 + 32'(4 * i));
            tick();
        end
        checkOutput("drain.done");

        // Load hazard against a buffered store to 0x40.
        applyStimulus(1'b1, 3'd2, 32'h40, 32'h0BAD_F00D, 1'b0, 32'h43);
        chk("hit.notYet", ld_hit, 1'b0);
        tick();
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h43);
        checkOutput("hit.same");
        chk("hit.sameWord", ld_hit, 1'b1);
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b0, 32'h44);
        checkOutput("hit.next");
        chk("hit.nextWord", ld_hit, 1'b0);
        applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h40);
        chk("hit.popping", ld_hit, 1'b1);
        tick();
        checkOutput("hit.done");

        // Steady push and pop at a depth of two, then reset mid-stream.
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b1, 3'd2, 32'h200 + 32'(4 * i), 32'(i), 1'b0, 32'h0);
            tick();
        end
        for (int i = 2; i < 10; i++) begin
            applyStimulus(1'b1, 3'd2, 32'h200 + 32'(4 * i), 32'(i), 1'b1, 32'h0);
            checkOutput("stream");
            chk("stream.head", mem_addr, 32'h200 + 32'(4 * (i - 2)));
            tick();
        end
        applyStimulus(1'b1, 3'd2, 32'h300, 32'h0, 1'b1, 32'h0);
        rst_n = 1'b0;
        #1;
        modelQ.delete();
        modelErr = 1'b0;
        checkOutput("rst.async");
        chk("rst.req", mem_req, 1'b0);
        chk("rst.empty", empty, 1'b1);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 3'd0, 32'h0, 32'h0, 1'b1, 32'h200);
            checkOutput("rst.quiet");
            tick();
        end

        // Randomized traffic, including illegal widths and misalignment.
        for (int i = 0; i < 300; i++) begin
            applyStimulus(1'($urandom_range(0, 1)), 3'($urandom_range(0, 3)),
                          32'h100 + 32'($urandom_range(0, 31)), $urandom,
                          ($urandom_range(0, 2) != 0), 32'h100 + 32'($urandom_range(0, 31)));
            checkOutput("rand");
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_store_buffer.md
Name: lsu_store_buffer

Overview:
- Downstream of the LSU store byte-enable logic. Takes the store stream from execute: address, funct3 and rs2 data.
- Per store: aligns data to byte lanes, forms the 4-bit byte-enable, and queues the result in a small FIFO.
- Drains entries in order to the data-memory write port over a req/gnt handshake.
- Gives the load path a word-address hazard flag, so loads stall while a matching store is still buffered.

Parameters:
- DEPTH, 4, number of buffered stores; power of two, minimum 2.
- AW, 32, byte-address width.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- st_valid  in  1  store request valid.
- st_ready  out  1  buffer can accept a store.
- st_addr  in  AW  byte address of the store.
- st_funct3  in  3  000 = SB, 001 = SH, 010 = SW.
- st_data  in  32  rs2 value, right-justified.
- st_err  out  1  one-cycle pulse when a store is rejected.
- mem_req  out  1  write request to data memory.
- mem_gnt  in  1  memory accepts the current request.
- mem_addr  out  AW  word-aligned address; bits [1:0] are always 0.
- mem_wdata  out  32  lane-aligned write data.
- mem_be  out  4  byte enables; bit n enables byte lane n.
- ld_addr  in  AW  address of the load currently in the LSU.
- ld_hit  out  1  a valid entry has the same word address as ld_addr.
- empty  out  1  no valid entries; used for fence/drain.

Behaviour:
- Reset: asynchronous on rst_n low. Read/write pointers = 0, count = 0, all entry valid bits = 0.
- Reset output values: mem_req = 0, st_err = 0, empty = 1, st_ready = 1, ld_hit = 0, mem_addr/mem_wdata/mem_be = 0.
- Reset mid-transaction discards all entries. No write is replayed.
- Accept: a handshake happens when st_valid && st_ready.
- st_ready = (count != DEPTH). It comes from registered state only, with no combinational path from mem_gnt.
- Legality check, on handshake:
  - SH needs st_addr[0] = 0.
  - SW needs st_addr[1:0] = 00.
  - funct3 must be 000, 001 or 010.
- Illegal store: not enqueued. st_err = 1 on the next cycle for exactly one cycle. Pointers unchanged.
- Alignment, with o = st_addr[1:0]:
  - SB: wdata = {4{st_data[7:0]}}, be = 0001 << o.
  - SH: wdata = {2{st_data[15:0]}}, be = 0011 << o.
  - SW: wdata = st_data, be = 1111.
- Each entry stores {addr[AW-1:2], wdata, be}.
- Latency: a store accepted in cycle N can appear on mem_req in cycle N+1 at the earliest, when the buffer was empty.
- Drain:
  - mem_req = (count != 0). Fields are driven from the head entry.
  - The head is popped on mem_req && mem_gnt.
  - While mem_req = 1 and mem_gnt = 0, mem_addr/mem_wdata/mem_be stay stable.
  - Strict FIFO order; no merging or coalescing.
- Simultaneous push and pop in the same cycle: count is unchanged and both pointers advance. Allowed whenever st_ready = 1 and count > 0.
- Full: st_ready = 0, so no push can occur. A pop while full brings st_ready back to 1 on the next cycle.
- Empty: mem_req = 0, and mem_gnt is ignored.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count is log2(DEPTH)+1 bits.
- ld_hit is combinational: the OR over valid entries of (entry.addr == ld_addr[AW-1:2]).
  - The check is word-granular and ignores byte enables (conservative).
  - An entry popped this cycle still counts as a hit this cycle.
  - A store accepted this cycle does not count until the next cycle.
- empty = (count == 0), registered.

Decomposition:
- Shared package lsu_pkg:
  - funct3 constants F3_SB, F3_SH, F3_SW.
  - BE_W = 4.
  - Typedef of the store-entry struct {word_addr, wdata, be}.
- One combinational sub-module, store_lane_align:
  - Inputs: funct3, addr[1:0], data.
  - Outputs: wdata, be, illegal.
  - Instantiated once at the push side.
- The FIFO storage and control stay in lsu_store_buffer.

Test Plan:
- SB at 0x1003, data 0xAB, mem_gnt = 1:
  - Next cycle: mem_req = 1, mem_addr = 0x1000, mem_be = 1000, mem_wdata = 0xABABABAB.
  - After the grant, empty = 1.
- SH at 0x2002, data 0x1234, mem_gnt held 0 for 3 cycles:
  - mem_be = 1100 and mem_wdata = 0x12341234, stable all 3 cycles.
  - Popped on the first grant.
- SW at 0x3001, and separately SH at 0x3001:
  - Neither is enqueued; st_err pulses once each cycle after the handshake.
  - empty stays 1 and mem_req stays 0.
- Push 4 SWs (0x10, 0x14, 0x18, 0x1C) with mem_gnt = 0:
  - st_ready = 0 after the 4th; a 5th st_valid is not accepted.
  - Raise mem_gnt: addresses drain in order 0x10, 0x14, 0x18, 0x1C, and st_ready returns 1 the cycle after the first pop.
- Buffer holding a store to 0x40, ld_addr = 0x43 -> ld_hit = 1; ld_addr = 0x44 -> ld_hit = 0.
- Continuous push and pop at count = 2 with mem_gnt = 1 for 8 cycles:
  - count stays 2 and pointers wrap.
  - Assert rst_n = 0 mid-stream: mem_req = 0 and empty = 1 immediately, and no further writes are issued.
